riscv_dmem_responder: RTL and testbench

- Data-memory responder that services load/store requests issued by the pipeline's MEM stage.
- Byte-addressed, little-endian storage with a configurable wait-state latency.
- Uses a request/response handshake; the core stalls MEM while a request is outstanding.
- The storage array is named mem, one byte per entry, so benches can preload and inspect it hierarchically.

---
 rtl/riscv_dmem_responder.sv | 96 +++++++++
 tb/tb_riscv_dmem_responder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_dmem_responder.sv
// riscv_dmem_responder: byte-addressed little-endian data memory with LATENCY wait states.
// Define RISCV_DMEM_MISALIGN_TRAP_EN to turn misaligned half/word accesses into error responses.
module riscv_dmem_responder #(
  parameter int MEM_BYTES = 128,
  parameter int LATENCY = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = $clog2(MEM_BYTES);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state;
  logic [3:0] cnt;
  logic we_q;
  logic [2:0] f3_q;
  logic [AW-1:0] idx_q;
  logic [31:0] wdata_q;
  logic [7:0] mem [MEM_BYTES];
  logic a_we;
  logic [2:0] a_f3;
  logic [AW-1:0] a_idx;
  logic [31:0] a_wdata;
  logic [7:0] b0, b1, b2, b3;
  logic [31:0] rd;
  logic legal, mis, err, commit;
  logic unused_addr;
  assign unused_addr = ^req_addr[31:AW];
  assign req_ready = state == IDLE;
  // With zero latency the commit edge is the accept edge, so the live request is used.
  assign a_we = req_ready ? req_we : we_q;
  assign a_f3 = req_ready ? req_funct3 : f3_q;
  assign a_idx = req_ready ? req_addr[AW-1:0] : idx_q;
  assign a_wdata = req_ready ? req_wdata : wdata_q;
  assign b0 = mem[a_idx];
  assign b1 = mem[a_idx + AW'(1)];
  assign b2 = mem[a_idx + AW'(2)];
  assign b3 = mem[a_idx + AW'(3)];
  assign rd = a_f3 == 3'b000 ? {{24{b0[7]}}, b0} :
              a_f3 == 3'b001 ? {{16{b1[7]}}, b1, b0} :
              a_f3 == 3'b100 ? {24'd0, b0} :
              a_f3 == 3'b101 ? {16'd0, b1, b0} : {b3, b2, b1, b0};
  assign legal = a_f3 == 3'b000 || a_f3 == 3'b001 || a_f3 == 3'b010 ||
                 (!a_we && (a_f3 == 3'b100 || a_f3 == 3'b101));
`ifdef RISCV_DMEM_MISALIGN_TRAP_EN
  assign mis = (a_f3[1:0] == 2'b01 && a_idx[0]) || (a_f3[1:0] == 2'b10 && a_idx[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif
  assign err = !legal || mis;
  assign commit = (state == IDLE && req_valid && LATENCY == 0) || (state == WAIT && cnt == 4'd1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
    end else begin
      resp_valid <= commit;
      if (commit) begin
        resp_rdata <= (a_we || err) ? '0 : rd;
        resp_err <= err;
        if (a_we && !err) begin
          mem[a_idx] <= a_wdata[7:0];
          if (a_f3[1:0] != 2'b00) mem[a_idx + AW'(1)] <= a_wdata[15:8];
          if (a_f3[1:0] == 2'b10) begin
            mem[a_idx + AW'(2)] <= a_wdata[23:16];
            mem[a_idx + AW'(3)] <= a_wdata[31:24];
          end
        end
      end
      if (state == IDLE && req_valid) begin
        we_q <= req_we;
        f3_q <= req_funct3;
        idx_q <= req_addr[AW-1:0];
        wdata_q <= req_wdata;
        cnt <= 4'(LATENCY);
        state <= LATENCY == 0 ? RESP : WAIT;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) state <= RESP;
      end else if (state == RESP) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_riscv_dmem_responder.sv
// tb_riscv_dmem_responder: scoreboard bench driving a zero-latency and a three-wait-state instance.
// Honours RISCV_DMEM_MISALIGN_TRAP_EN to pick the expected misaligned behaviour.
module tb_riscv_dmem_responder;
  localparam int MEM = 128;
  logic clk = 0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [1:0] rs, rv, rwe, rdy, vld, err;
  logic [1:0][2:0] rf3;
  logic [1:0][31:0] raddr, rwd, rdat;
  riscv_dmem_responder #(.MEM_BYTES(MEM), .LATENCY(0)) u0 (
    .clk(clk), .reset(rs[0]), .req_valid(rv[0]), .req_ready(rdy[0]), .req_we(rwe[0]),
    .req_funct3(rf3[0]), .req_addr(raddr[0]), .req_wdata(rwd[0]),
    .resp_valid(vld[0]), .resp_rdata(rdat[0]), .resp_err(err[0]));
  riscv_dmem_responder #(.MEM_BYTES(MEM), .LATENCY(3)) u1 (
    .clk(clk), .reset(rs[1]), .req_valid(rv[1]), .req_ready(rdy[1]), .req_we(rwe[1]),
    .req_funct3(rf3[1]), .req_addr(raddr[1]), .req_wdata(rwd[1]),
    .resp_valid(vld[1]), .resp_rdata(rdat[1]), .resp_err(err[1]));
  typedef struct {logic [31:0] rd; logic e; int at;} exp_t;
  exp_t sb0[$], sb1[$];
  logic [7:0] mm [2][MEM];
  logic [31:0] hold_rd [2];
  logic hold_e [2];
  int checks = 0, fails = 0;
  function automatic int lat(int i);
    return i == 0 ? 0 : 3;
  endfunction
  function automatic logic [7:0] dmem(int i, int a);
    return i == 0 ? u0.mem[a] : u1.mem[a];
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask
  // Reference: a request touches n consecutive bytes modulo MEM; loads sign-extend when funct3[2]==0.
  task automatic model(input int i, input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic e);
    int n;
    logic [31:0] v;
    n = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
    e = !(f3 <= 3'd2 || (!we && (f3 == 3'd4 || f3 == 3'd5)));
`ifdef RISCV_DMEM_MISALIGN_TRAP_EN
    if (a % n != 0) e = 1'b1;
`endif
    rd = '0;
    v = '0;
    if (!e) for (int k = 0; k < n; k++) begin
      if (we) mm[i][(a + k) % MEM] = wd[8*k +: 8];
      else v[8*k +: 8] = mm[i][(a + k) % MEM];
    end
    if (!e && !we) rd = (!f3[2] && n < 4 && v[8*n-1]) ? v - (32'd1 << (8*n)) : v;
  endtask
  task automatic push(input int i, input exp_t x);
    if (i == 0) sb0.push_back(x);
    else sb1.push_back(x);
  endtask
  task automatic issue(input int i, input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit fix, input logic [31:0] xrd, input logic xe);
    exp_t x;
    int n = 0;
    @(negedge clk);
    rv[i] = 1'b1; rwe[i] = we; rf3[i] = f3; raddr[i] = a; rwd[i] = wd;
    while (!rdy[i] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("u%0d ready wait", i), rdy[i], 1'b1);
    if (!rdy[i]) begin
      rv[i] = 1'b0;
      return;
    end
    model(i, we, f3, a, wd, x.rd, x.e);
    if (fix) begin
      x.rd = xrd;
      x.e = xe;
    end
    x.at = cyc + 1 + lat(i);
    push(i, x);
    @(negedge clk);
    rv[i] = 1'b0; rwe[i] = 1'($urandom); rf3[i] = 3'($urandom); raddr[i] = $urandom; rwd[i] = $urandom;
  endtask
  task automatic drain;
    int n = 0;
    while ((sb0.size() != 0 || sb1.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain pending", sb0.size() + sb1.size(), 0);
    @(negedge clk);
  endtask
  // Accept a load, check the ready profile, then accept again on the first ready cycle.
  task automatic timeline(input int i);
    exp_t x;
    logic [31:0] a;
    drain();
    a = $urandom;
    rv[i] = 1'b1; rwe[i] = 1'b0; rf3[i] = 3'b010; raddr[i] = a;
    model(i, 1'b0, 3'b010, a, 32'd0, x.rd, x.e);
    x.at = cyc + 1 + lat(i);
    push(i, x);
    for (int k = 1; k <= lat(i) + 2; k++) begin
      @(negedge clk);
      rv[i] = 1'b0;
      chk($sformatf("u%0d ready at accept+%0d", i, k), rdy[i], 1'(k == lat(i) + 2));
    end
    a = $urandom;
    rv[i] = 1'b1; rf3[i] = 3'b100; raddr[i] = a;
    model(i, 1'b0, 3'b100, a, 32'd0, x.rd, x.e);
    x.at = cyc + 1 + lat(i);
    push(i, x);
    @(negedge clk);
    rv[i] = 1'b0;
  endtask
  // Store 0x11223344 to address 8 and reset `when` cycles after the accept edge (0 = on it).
  task automatic abort(input int i, input int when);
    issue(i, 1'b1, 3'b010, 32'd8, 32'd0, 1'b0, 32'd0, 1'b0);
    drain();
    rv[i] = 1'b1; rwe[i] = 1'b1; rf3[i] = 3'b010; raddr[i] = 32'd8; rwd[i] = 32'h11223344;
    if (when == 0) rs[i] = 1'b1;
    else begin
      @(negedge clk);
      rv[i] = 1'b0;
      repeat (when - 1) @(negedge clk);
      rs[i] = 1'b1;
    end
    @(negedge clk);
    rs[i] = 1'b0;
    rv[i] = 1'b0;
    chk($sformatf("u%0d ready after abort %0d", i, when), rdy[i], 1'b1);
    repeat (lat(i) + 3) @(negedge clk);
    for (int k = 0; k < 4; k++) chk($sformatf("u%0d abort %0d mem[%0d]", i, when, 8 + k), dmem(i, 8 + k), 8'h00);
  endtask
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < 2; i++) begin
      exp_t x;
      bit due;
      due = 0;
      if (i == 0 && sb0.size() != 0) begin
        x = sb0[0];
        due = cyc >= x.at;
        if (due) void'(sb0.pop_front());
      end
      if (i == 1 && sb1.size() != 0) begin
        x = sb1[0];
        due = cyc >= x.at;
        if (due) void'(sb1.pop_front());
      end
      if (rs[i]) begin
        chk($sformatf("u%0d reset resp_valid", i), vld[i], 1'b0);
        chk($sformatf("u%0d reset resp_rdata", i), rdat[i], 32'd0);
        chk($sformatf("u%0d reset resp_err", i), err[i], 1'b0);
        hold_rd[i] = '0;
        hold_e[i] = 1'b0;
      end else if (due) begin
        chk($sformatf("u%0d resp_valid at cycle %0d", i, x.at), vld[i], 1'b1);
        chk($sformatf("u%0d resp_rdata", i), rdat[i], x.rd);
        chk($sformatf("u%0d resp_err", i), err[i], x.e);
        hold_rd[i] = x.rd;
        hold_e[i] = x.e;
      end else begin
        chk($sformatf("u%0d spurious resp_valid", i), vld[i], 1'b0);
        chk($sformatf("u%0d resp_rdata hold", i), rdat[i], hold_rd[i]);
        chk($sformatf("u%0d resp_err hold", i), err[i], hold_e[i]);
      end
    end
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int ii;
    logic we;
    logic [2:0] f3;
    logic [31:0] a;
    logic [7:0] pre [4];
    rs = '1; rv = '0; rwe = '0; rf3 = '0; raddr = '0; rwd = '0;
    for (int i = 0; i < 2; i++) begin
      hold_rd[i] = '0;
      hold_e[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rs = '0;
    chk("u0 ready after reset", rdy[0], 1'b1);
    chk("u1 ready after reset", rdy[1], 1'b1);
    for (int k = 0; k < MEM; k += 4) begin
      issue(0, 1'b1, 3'b010, k, $urandom, 1'b0, 32'd0, 1'b0);
      issue(1, 1'b1, 3'b010, k, $urandom, 1'b0, 32'd0, 1'b0);
    end
    issue(0, 1'b1, 3'b000, 32'd0, 32'h7, 1'b1, 32'd0, 1'b0);
    issue(0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b1, 32'h7, 1'b0);
    drain();
    chk("sb mem[0]", dmem(0, 0), 8'h07);
    pre = '{8'h80, 8'hFF, 8'h12, 8'h34};
    for (int k = 0; k < 4; k++) issue(0, 1'b1, 3'b000, 4 + k, {24'd0, pre[k]}, 1'b1, 32'd0, 1'b0);
    issue(0, 1'b0, 3'b001, 32'd4, 32'd0, 1'b1, 32'hFFFFFF80, 1'b0);
    issue(0, 1'b0, 3'b101, 32'd4, 32'd0, 1'b1, 32'h0000FF80, 1'b0);
    issue(0, 1'b0, 3'b010, 32'd4, 32'd0, 1'b1, 32'h3412FF80, 1'b0);
    issue(0, 1'b0, 3'b000, 32'd5, 32'd0, 1'b1, 32'hFFFFFFFF, 1'b0);
    issue(0, 1'b1, 3'b010, 32'd126, 32'hAABBCCDD, 1'b1, 32'd0, 1'b0);
    drain();
    chk("wrap mem[126]", dmem(0, 126), 8'hDD);
    chk("wrap mem[127]", dmem(0, 127), 8'hCC);
    chk("wrap mem[0]", dmem(0, 0), 8'hBB);
    chk("wrap mem[1]", dmem(0, 1), 8'hAA);
    for (int k = 0; k < 4; k++) issue(0, 1'b1, 3'b000, 2 + k, k + 1, 1'b1, 32'd0, 1'b0);
`ifdef RISCV_DMEM_MISALIGN_TRAP_EN
    issue(0, 1'b0, 3'b010, 32'd2, 32'd0, 1'b1, 32'd0, 1'b1);
    issue(0, 1'b1, 3'b010, 32'd2, 32'hDEADBEEF, 1'b1, 32'd0, 1'b1);
    drain();
    for (int k = 0; k < 4; k++) chk($sformatf("misaligned sw mem[%0d]", 2 + k), dmem(0, 2 + k), k + 1);
`else
    issue(0, 1'b0, 3'b010, 32'd2, 32'd0, 1'b1, 32'h04030201, 1'b0);
    issue(0, 1'b1, 3'b010, 32'd2, 32'hDEADBEEF, 1'b1, 32'd0, 1'b0);
    drain();
    chk("misaligned sw mem[2]", dmem(0, 2), 8'hEF);
    chk("misaligned sw mem[5]", dmem(0, 5), 8'hDE);
`endif
    issue(0, 1'b0, 3'b011, 32'd8, 32'd0, 1'b1, 32'd0, 1'b1);
    issue(0, 1'b0, 3'b110, 32'd8, 32'd0, 1'b1, 32'd0, 1'b1);
    issue(0, 1'b1, 3'b100, 32'd8, 32'hFFFFFFFF, 1'b1, 32'd0, 1'b1);
    issue(1, 1'b1, 3'b011, 32'd8, 32'hFFFFFFFF, 1'b1, 32'd0, 1'b1);
    drain();
    chk("u0 illegal store mem[8]", dmem(0, 8), mm[0][8]);
    chk("u1 illegal store mem[8]", dmem(1, 8), mm[1][8]);
    timeline(0);
    timeline(1);
    abort(0, 0);
    abort(1, 1);
    abort(1, 3);
    repeat (300) begin
      ii = $urandom_range(0, 1);
      we = 1'($urandom);
      f3 = 3'($urandom);
      a = $urandom;
      issue(ii, we, f3, a, $urandom, 1'b0, 32'd0, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < MEM; k++) chk($sformatf("u%0d final mem[%0d]", i, k), dmem(i, k), mm[i][k]);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
